// File: rtl/dyser_functional_unit_pkg.sv
// rtl/dyser_functional_unit_pkg.sv - shared width, direction codes and opcodes for the DySER tile
`ifndef PATH_WIDTH
`define PATH_WIDTH 64
`endif

package dyser_functional_unit_pkg;
  localparam int PATH_WIDTH = `PATH_WIDTH;

  typedef enum logic [1:0] {
    DIR_NW = 2'd0,
    DIR_NE = 2'd1,
    DIR_SW = 2'd2,
    DIR_SE = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } opcode_e;
endpackage

// File: rtl/dyser_functional_unit_if.sv
// rtl/dyser_functional_unit_if.sv - token, credit and configuration bundle for one DySER tile
interface dyser_functional_unit_if;
  import dyser_functional_unit_pkg::*;

  logic [PATH_WIDTH:0] d_in_NW;
  logic [PATH_WIDTH:0] d_in_NE;
  logic [PATH_WIDTH:0] d_in_SE;
  logic [PATH_WIDTH:0] d_in_SW;
  logic                c_in_SE;
  logic [5:0]          conf;
  logic                c_out_NW;
  logic                c_out_NE;
  logic                c_out_SE;
  logic                c_out_SW;
  logic [PATH_WIDTH:0] d_out_SE;

  modport master (
    output d_in_NW, d_in_NE, d_in_SE, d_in_SW, c_in_SE, conf,
    input  c_out_NW, c_out_NE, c_out_SE, c_out_SW, d_out_SE
  );

  modport slave (
    input  d_in_NW, d_in_NE, d_in_SE, d_in_SW, c_in_SE, conf,
    output c_out_NW, c_out_NE, c_out_SE, c_out_SW, d_out_SE
  );
endinterface

// File: rtl/dyser_functional_unit_fu_comp_logic.sv
// rtl/dyser_functional_unit_fu_comp_logic.sv - combinational ALU of the tile
module fu_comp_logic
  import dyser_functional_unit_pkg::*;
(
  input  opcode_e               opcode,
  input  logic [PATH_WIDTH-1:0] a,
  input  logic [PATH_WIDTH-1:0] b,
  output logic [PATH_WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_AND: result = a & b;
      OP_XOR: result = a ^ b;
    endcase
  end

endmodule

// File: rtl/dyser_functional_unit.sv
// rtl/dyser_functional_unit.sv - DySER compute tile: operand capture, credit flow control, result register
module dyser_functional_unit
  import dyser_functional_unit_pkg::*;
#(
  parameter int INDEX = 0
) (
  input logic                    clk,
  input logic                    rst,
  dyser_functional_unit_if.slave bus
);

  if (INDEX < 0) begin : g_bad_index
    $error("dyser_functional_unit: INDEX must be non-negative");
  end

  logic [PATH_WIDTH:0]   ports [4];
  logic [PATH_WIDTH:0]   tok0;
  logic [PATH_WIDTH:0]   tok1;
  logic [1:0]            src0;
  logic [1:0]            src1;
  opcode_e               opcode;
  logic [PATH_WIDTH-1:0] b0;
  logic [PATH_WIDTH-1:0] b1;
  logic [PATH_WIDTH-1:0] result;
  logic                  b0_full;
  logic                  b1_full;
  logic                  credit;
  logic                  fire;
  logic [PATH_WIDTH:0]   d_out;
  logic [3:0]            c_out;

  assign ports[DIR_NW] = bus.d_in_NW;
  assign ports[DIR_NE] = bus.d_in_NE;
  assign ports[DIR_SW] = bus.d_in_SW;
  assign ports[DIR_SE] = bus.d_in_SE;

  assign src0   = bus.conf[3:2];
  assign src1   = bus.conf[1:0];
  assign opcode = opcode_e'(bus.conf[5:4]);
  assign tok0   = ports[src0];
  assign tok1   = ports[src1];
  assign fire   = b0_full & b1_full & credit;

  fu_comp_logic u_comp (
    .opcode (opcode),
    .a      (b0),
    .b      (b1),
    .result (result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b0      <= '0;
      b1      <= '0;
      b0_full <= 1'b0;
      b1_full <= 1'b0;
      credit  <= 1'b1;
      d_out   <= '0;
      c_out   <= '0;
    end else begin
      c_out    <= '0;
      d_out[0] <= 1'b0;
      if (fire) begin
        d_out         <= {result, 1'b1};
        b0_full       <= 1'b0;
        b1_full       <= 1'b0;
        // Same-source config sets the same bit twice: one pulse back to that neighbour.
        c_out[src0]   <= 1'b1;
        c_out[src1]   <= 1'b1;
      end else begin
        if (!b0_full && tok0[0]) begin
          b0      <= tok0[PATH_WIDTH:1];
          b0_full <= 1'b1;
        end
        if (!b1_full && tok1[0]) begin
          b1      <= tok1[PATH_WIDTH:1];
          b1_full <= 1'b1;
        end
      end
      // A credit returning in the fire cycle wins, so the flag never loses a credit.
      credit <= bus.c_in_SE | (credit & ~fire);
    end
  end

  assign bus.d_out_SE = d_out;
  assign bus.c_out_NW = c_out[DIR_NW];
  assign bus.c_out_NE = c_out[DIR_NE];
  assign bus.c_out_SW = c_out[DIR_SW];
  assign bus.c_out_SE = c_out[DIR_SE];

endmodule

// File: tb/tb_dyser_functional_unit.sv
// tb/tb_dyser_functional_unit.sv - directed vector bench for the DySER compute tile
module tb_dyser_functional_unit;
  import dyser_functional_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  dyser_functional_unit_if bus ();

  dyser_functional_unit #(.INDEX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  conf;
    logic [3:0]  valid;   // {SE, SW, NE, NW}
    logic [63:0] nw, ne, sw, se;
    logic [63:0] result;
    logic [3:0]  credits; // {SE, SW, NE, NW}
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] couts();
    return {bus.c_out_SE, bus.c_out_SW, bus.c_out_NE, bus.c_out_NW};
  endfunction

  task automatic drive(input logic [3:0] v, input logic [63:0] nw, ne, sw, se);
    bus.d_in_NW = {nw, v[0]};
    bus.d_in_NE = {ne, v[1]};
    bus.d_in_SW = {sw, v[2]};
    bus.d_in_SE = {se, v[3]};
  endtask

  task automatic idle();
    drive(4'b0000, '0, '0, '0, '0);
  endtask

  task automatic expect_quiet(input string name);
    check({name, "_valid"}, bus.d_out_SE[0], 1'b0);
    check({name, "_cout"}, couts(), 4'b0000);
  endtask

  task automatic expect_fire(input string name, input logic [63:0] res, input logic [3:0] cm);
    check({name, "_dout"}, bus.d_out_SE, {res, 1'b1});
    check({name, "_cout"}, couts(), cm);
  endtask

  int   nw_cnt, sw_cnt, out_cnt;
  bit   cnw, csw, drain;

  initial begin
    vecs[0] = '{"add_nw_sw",   6'b00_00_10, 4'b0101, 64'd5,   64'd0,       64'd7,   64'd0,       64'd12,      4'b0101};
    vecs[1] = '{"sub_ne_se",   6'b01_01_11, 4'b1010, 64'd0,   64'd10,      64'd0,   64'd3,       64'd7,       4'b1010};
    vecs[2] = '{"xor_sw_nw",   6'b11_10_00, 4'b0101, 64'hFF,  64'd0,       64'hF0,  64'd0,       64'h0F,      4'b0101};
    vecs[3] = '{"and_se_ne",   6'b10_11_01, 4'b1010, 64'd0,   64'h0F0F0F,  64'd0,   64'hFF00FF,  64'h0F000F,  4'b1010};
    vecs[4] = '{"sub_wrap",    6'b01_00_01, 4'b0011, 64'd3,   64'd5,       64'd0,   64'd0,       64'hFFFF_FFFF_FFFF_FFFE, 4'b0011};
    vecs[5] = '{"add_wrap",    6'b00_10_11, 4'b1100, 64'd0,   64'd0,       {64{1'b1}}, 64'd2,    64'd1,       4'b1100};
    vecs[6] = '{"same_src_se", 6'b00_11_11, 4'b1000, 64'd0,   64'd0,       64'd0,   64'd9,       64'd18,      4'b1000};
    vecs[7] = '{"unsel_valid", 6'b00_00_01, 4'b1111, 64'd1,   64'd2,       64'd100, 64'd200,     64'd3,       4'b0011};

    rst = 1'b0;
    bus.conf = 6'b00_00_10;
    bus.c_in_SE = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 expect_quiet("in_reset");
    rst = 1'b1;
    @(posedge clk);
    #1 expect_quiet("after_reset");

    bus.c_in_SE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.conf = vecs[i].conf;
      @(posedge clk);
      #1 drive(vecs[i].valid, vecs[i].nw, vecs[i].ne, vecs[i].sw, vecs[i].se);
      @(posedge clk);
      #1 idle();
      expect_quiet({vecs[i].name, "_capture"});
      @(posedge clk);
      #1 expect_fire(vecs[i].name, vecs[i].result, vecs[i].credits);
      @(posedge clk);
      #1 expect_quiet({vecs[i].name, "_after"});
    end

    // Backpressure: first fire consumes the credit, second pair must stall.
    bus.conf = 6'b00_00_10;
    bus.c_in_SE = 1'b0;
    drive(4'b0101, 64'd1, 0, 64'd2, 0);
    @(posedge clk);
    #1 idle();
    @(posedge clk);
    #1 expect_fire("bp_first", 64'd3, 4'b0101);
    drive(4'b0101, 64'd10, 0, 64'd20, 0);
    @(posedge clk);
    #1 drive(4'b0001, 64'd99, 0, 0, 0);
    @(posedge clk);
    #1 idle();
    expect_quiet("bp_stall0");
    @(posedge clk);
    #1 expect_quiet("bp_stall1");
    bus.c_in_SE = 1'b1;
    @(posedge clk);
    #1 expect_quiet("bp_credit_edge");
    @(posedge clk);
    #1 expect_fire("bp_release", 64'd30, 4'b0101);
    bus.c_in_SE = 1'b0;
    drive(4'b0101, 64'd4, 0, 64'd6, 0);
    @(posedge clk);
    #1 idle();
    @(posedge clk);
    #1 expect_fire("credit_kept_on_fire", 64'd10, 4'b0101);
    @(posedge clk);
    #1 expect_quiet("credit_after_fire");

    // Reset mid-operation drops a half-filled operand pair and restores the credit.
    drive(4'b0001, 64'd7, 0, 0, 0);
    @(posedge clk);
    #1 idle();
    rst = 1'b0;
    #2 expect_quiet("mid_reset");
    rst = 1'b1;
    @(posedge clk);
    #1 drive(4'b0100, 0, 0, 64'd8, 0);
    @(posedge clk);
    #1 idle();
    @(posedge clk);
    #1 expect_quiet("dropped_operand");
    drive(4'b0001, 64'd1, 0, 0, 0);
    @(posedge clk);
    #1 idle();
    @(posedge clk);
    #1 expect_fire("after_mid_reset", 64'd9, 4'b0101);

    // Credit-gated stream: k-th NW token is k, k-th SW token is k+1, so output k is 2k+1.
    bus.conf = 6'b00_00_10;
    nw_cnt = 0; sw_cnt = 0; out_cnt = 0;
    cnw = 1'b1; csw = 1'b1;
    for (int cyc = 0; cyc < 140; cyc++) begin
      @(posedge clk);
      #1;
      drain = (cyc >= 100);
      if (bus.c_out_NW) cnw = 1'b1;
      if (bus.c_out_SW) csw = 1'b1;
      if (bus.d_out_SE[0]) begin
        check("stream_out", bus.d_out_SE[64:1], 64'(2 * out_cnt + 1));
        out_cnt++;
      end
      bus.c_in_SE = drain ? 1'b1 : 1'($urandom_range(0, 1));
      if (cnw && (drain ? (nw_cnt < sw_cnt) : ($urandom_range(0, 1) == 1))) begin
        bus.d_in_NW = {64'(nw_cnt), 1'b1};
        cnw = 1'b0;
        nw_cnt++;
      end else begin
        bus.d_in_NW = '0;
      end
      if (csw && (drain ? (sw_cnt < nw_cnt) : ($urandom_range(0, 1) == 1))) begin
        bus.d_in_SW = {64'(sw_cnt + 1), 1'b1};
        csw = 1'b0;
        sw_cnt++;
      end else begin
        bus.d_in_SW = '0;
      end
    end
    check("stream_count_nw", 128'(out_cnt), 128'(nw_cnt));
    check("stream_count_sw", 128'(out_cnt), 128'(sw_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dyser_functional_unit.md
Name: dyser_functional_unit

Overview:
- One DySER compute tile. Two operands are selected from the four diagonal input ports (NW/NE/SE/SW). Each port is PATH_WIDTH data bits plus a valid bit.
- The tile applies a 2-bit opcode and emits the result on d_out_SE.
- Flow control is credit-based: a one-cycle credit pulse goes back to each source when its operand is consumed, and one downstream credit is held for SE.

Parameters:
- INDEX, default 0: tile identifier for instantiation and debug only; it has no functional effect.
- PATH_WIDTH (shared `define), default 64: data width. Every bus is [PATH_WIDTH:0], with bit 0 = valid and [PATH_WIDTH:1] = data.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- d_in_NW, d_in_NE, d_in_SE, d_in_SW  in  PATH_WIDTH+1 each  input tokens; [0] = valid.
- c_in_SE  in  1  downstream credit return; one-cycle pulse, 1 = one credit.
- conf  in  6  [1:0] = operand1 source, [3:2] = operand0 source, [5:4] = opcode. Source codes: 00 = NW, 01 = NE, 10 = SW, 11 = SE.
- c_out_NW, c_out_NE, c_out_SE, c_out_SW  out  1 each  credit pulse to each upstream neighbour.
- d_out_SE  out  PATH_WIDTH+1  result token; [0] = valid.

Behaviour:
- Reset (rst=0, asynchronous): d_out_SE = 0 (valid low); all c_out = 0; both operand buffers empty; downstream credit flag = 1.
- Operand capture:
  - Operand buffer 0 loads data [PATH_WIDTH:1] at a posedge where the input port selected by conf[3:2] has valid = 1 and buffer 0 is empty. Buffer 1 works the same way using conf[1:0].
  - A valid input that arrives while its buffer is full is ignored; this is a protocol violation.
  - Valid on a non-selected port is ignored.
- Fire condition: both buffers full AND downstream credit = 1. On that posedge:
  - Register d_out_SE = {op(b0, b1), 1'b1}.
  - Clear both buffers.
  - Clear the downstream credit.
  - Pulse the c_out of each selected source direction high for exactly that one cycle.
- Outside a fire cycle, d_out_SE valid = 0 and the data field holds its last value. All c_out are 0 except on fire cycles.
- Latency: the second operand is valid at edge k → result valid and credit pulses after edge k+1, provided a downstream credit is held.
- Downstream credit:
  - Single-bit flag. Set by c_in_SE = 1 and cleared on fire.
  - If c_in_SE arrives in the same cycle as a fire, the flag ends at 1.
  - Extra credits saturate at 1.
- Opcodes, full PATH_WIDTH, results wrap modulo 2^PATH_WIDTH: 00 = b0 + b1; 01 = b0 − b1; 10 = b0 & b1; 11 = b0 ^ b1.
- Same-source configuration (conf[1:0] == conf[3:2]): one input token fills both buffers, and the fire returns a single c_out pulse on that direction.
- Simultaneous events: capture into an empty buffer in the same cycle as a fire is not possible, because upstream holds only one credit. Buffers are single-entry.
- conf is static while tokens are in flight. Changing it with full buffers is undefined.
- Reset mid-operation drops buffered operands and restores the credit flag to 1.

Decomposition:
- Shared package/defines: PATH_WIDTH; direction codes (NW = 0, NE = 1, SW = 2, SE = 3); opcode constants (ADD, SUB, AND, XOR).
- One sub-module: fu_comp_logic, combinational: (opcode, a, b) → result.
- Operand muxing, buffers, credit flag and output register stay in the top module.

Test Plan:
- Reset: hold rst = 0 for one cycle, then release → d_out_SE[0] = 0, all c_out = 0.
- Directed add, conf = 6'b00_00_10: NW = 5 and SW = 7 in the same cycle → next cycle d_out_SE = {12, 1}; c_out_NW and c_out_SW pulse once; c_out_NE and c_out_SE stay 0.
- Credit-gated stream with the add config:
  - 100 cycles. NW and SW send incrementing values (n, n+1) only when holding a credit (refilled on c_out), with random valid.
  - c_in_SE is random.
  - Every output = previous output + 2. After draining with c_in_SE = 1, the output count equals the NW count and the SW count.
- Backpressure: operands ready but no downstream credit (consumed by a prior fire, c_in_SE = 0) → no output and no c_out. Pulse c_in_SE → fires on the next edge.
- Random configurations (100 trials, distinct sources, random opcode, c_in_SE = 1, random 32-bit data on the selected ports) → output matches ADD/SUB/AND/XOR of operand0 and operand1 as defined above (e.g. SUB with 10, 3 → 7; XOR with 0xF0, 0xFF → 0x0F). Each selected source receives exactly one credit pulse per result.
- Source SE with same-source config (conf = 6'b00_11_11): SE = 9 → result 18, one c_out_SE pulse.
